// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per clock, streaming back-to-back words with no idle gap.
module piso_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_serial_out,
  output logic             o_serial_valid,
  output logic             o_frame_start,
  output logic             o_frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_serial_out;
  logic             r_serial_valid;
  logic             r_frame_start;
  logic             r_frame_done;

  logic             w_ready;
  logic             w_accept;
  logic             w_load_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shift_rest;

  // The first bit goes straight to the output register; r_shift holds only the bits still to send.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_load_bit   = i_in_data[WIDTH-1];
      assign w_load_rest  = {i_in_data[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_shift_rest = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_bit   = i_in_data[0];
      assign w_load_rest  = {1'b0, i_in_data[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_shift_rest = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_ready  = i_reset && ((r_state == ST_IDLE) || (r_cnt == '0));
  assign w_accept = w_ready && i_in_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_serial_out   <= IDLE_LEVEL;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_accept) begin
        r_state        <= ST_SHIFT;
        r_shift        <= w_load_rest;
        r_cnt          <= CW'(WIDTH - 1);
        r_serial_out   <= w_load_bit;
        r_serial_valid <= 1'b1;
        r_frame_start  <= 1'b1;
      end else if ((r_state == ST_SHIFT) && (r_cnt != '0)) begin
        r_shift      <= w_shift_rest;
        r_cnt        <= r_cnt - 1'b1;
        r_serial_out <= w_next_bit;
        // Counter reaching zero means the bit being presented is the word's last one.
        if (r_cnt == CW'(1)) begin
          r_frame_done <= 1'b1;
        end
      end else begin
        r_state        <= ST_IDLE;
        r_cnt          <= '0;
        r_serial_out   <= IDLE_LEVEL;
        r_serial_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready     = w_ready;
  assign o_serial_out   = r_serial_out;
  assign o_serial_valid = r_serial_valid;
  assign o_frame_start  = r_frame_start;
  assign o_frame_done   = r_frame_done;

endmodule
